// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl - AES key-schedule word controller.
// For each expanded-key word index i (NK .. 4*(NK+7)-1) presents one
// descriptor: index, Rcon word and the RotWord/SubWord transform flags.
// Rcon is produced by repeated GF(2^8) xtime instead of a lookup table.
//
// Parameters: BYTE (byte width), DWORD (word width), NK (4/6/8 key words),
//             POLY (xtime reduction byte).
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start, abort    begin a schedule (idle only) / cancel a running one
//   busy            schedule in progress
//   out_valid/ready descriptor handshake
//   out_idx         word index i
//   out_rcon        {rcon, 0...} when i mod NK == 0, else 0
//   out_rot_sub     i mod NK == 0
//   out_sub_only    NK == 8 and i mod 8 == 4
//   out_last        final word index
//   done            one-cycle pulse after the last descriptor is accepted
//   err             (only with KEY_SCHED_CTRL_ERR_EN) sticky misuse flag
//
// Optional feature macro: KEY_SCHED_CTRL_ERR_EN adds the err output.
module key_sched_ctrl #(
  parameter int unsigned         BYTE  = 8,
  parameter int unsigned         DWORD = 32,
  parameter int unsigned         NK    = 4,
  parameter logic [BYTE-1:0]     POLY  = 8'h1b
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_idx,
  output logic [DWORD-1:0] out_rcon,
  output logic             out_rot_sub,
  output logic             out_sub_only,
  output logic             out_last,
  output logic             done
`ifdef KEY_SCHED_CTRL_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [5:0] FIRST_IDX = 6'(NK);
  localparam logic [5:0] LAST_IDX  = 6'(4 * (NK + 7) - 1);
  localparam logic [2:0] PH_MAX    = 3'(NK - 1);
  localparam logic       NK_BAD    = (NK != 4) && (NK != 6) && (NK != 8);

`ifndef KEY_SCHED_CTRL_ERR_EN
  if (NK_BAD) begin : g_bad_nk
    $error("key_sched_ctrl: NK must be 4, 6 or 8");
  end
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [2:0]      phase_q, phase_d;
  logic [BYTE-1:0] rcon_q, rcon_d;
  logic            done_q, done_d;
  logic            run, beat, is_last;

  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] x);
    return {x[BYTE-2:0], 1'b0} ^ (x[BYTE-1] ? POLY : '0);
  endfunction

  assign run     = (state_q == RUN);
  assign beat    = run & out_ready;
  assign is_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      phase_q <= '0;
      rcon_q  <= BYTE'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = FIRST_IDX;
          phase_d = '0;
          rcon_d  = BYTE'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
          // phase tracks i mod NK incrementally, so no divider is needed
          phase_d = (phase_q == PH_MAX) ? '0 : phase_q + 3'd1;
          if (phase_q == '0) rcon_d = xtime(rcon_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Descriptor fields decode only registered state, and are forced to zero
  // outside RUN so idle outputs match the reset values.
  always_comb begin
    busy         = run;
    out_valid    = run;
    out_idx      = run ? idx_q : '0;
    out_rot_sub  = run && (phase_q == '0);
    out_sub_only = run && (NK == 8) && (phase_q == 3'd4);
    out_last     = run && is_last;
    out_rcon     = out_rot_sub ? {rcon_q, {(DWORD-BYTE){1'b0}}} : '0;
    done         = done_q;
  end

`ifdef KEY_SCHED_CTRL_ERR_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | NK_BAD | (start & run);
  end
  assign err = err_q;
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
module tb_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b0;

  logic        busy_o  [3];
  logic        valid_o [3];
  logic        rot_o   [3];
  logic        sub_o   [3];
  logic        last_o  [3];
  logic        done_o  [3];
  logic [5:0]  idx_o   [3];
  logic [31:0] rcon_o  [3];
`ifdef KEY_SCHED_CTRL_ERR_EN
  logic        err_o   [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    key_sched_ctrl #(.NK(4 + 2 * g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .busy         (busy_o[g]),
      .out_valid    (valid_o[g]),
      .out_ready    (ready),
      .out_idx      (idx_o[g]),
      .out_rcon     (rcon_o[g]),
      .out_rot_sub  (rot_o[g]),
      .out_sub_only (sub_o[g]),
      .out_last     (last_o[g]),
      .done         (done_o[g])
`ifdef KEY_SCHED_CTRL_ERR_EN
      ,
      .err          (err_o[g])
`endif
    );
  end

  // Reference model: schedule position per instance, Rcon from the FIPS-197 table
  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int m_run  [3];
  int m_i    [3];
  int m_done [3];
  int m_err  [3];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    for (int g = 0; g < 3; g++) begin
      int nk = 4 + 2 * g;
      int lst = 4 * (nk + 7) - 1;
      bit rs = (m_run[g] != 0) && (m_i[g] % nk == 0);
      bit so = (m_run[g] != 0) && (nk == 8) && (m_i[g] % 8 == 4);
      logic [31:0] er = rs ? {rc_tab[m_i[g] / nk - 1], 24'h0} : 32'h0;
      chk($sformatf("busy_nk%0d", nk),  32'(busy_o[g]),  32'(m_run[g] != 0));
      chk($sformatf("valid_nk%0d", nk), 32'(valid_o[g]), 32'(m_run[g] != 0));
      chk($sformatf("idx_nk%0d", nk),   32'(idx_o[g]),   (m_run[g] != 0) ? 32'(m_i[g]) : 32'h0);
      chk($sformatf("rcon_nk%0d", nk),  rcon_o[g],       er);
      chk($sformatf("rot_nk%0d", nk),   32'(rot_o[g]),   32'(rs));
      chk($sformatf("sub_nk%0d", nk),   32'(sub_o[g]),   32'(so));
      chk($sformatf("last_nk%0d", nk),  32'(last_o[g]),  32'((m_run[g] != 0) && (m_i[g] == lst)));
      chk($sformatf("done_nk%0d", nk),  32'(done_o[g]),  32'(m_done[g]));
`ifdef KEY_SCHED_CTRL_ERR_EN
      chk($sformatf("err_nk%0d", nk),   32'(err_o[g]),   32'(m_err[g]));
`endif
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      m_run[g] = 0; m_i[g] = 0; m_done[g] = 0; m_err[g] = 0;
    end
  endtask

  task automatic model_edge();
    for (int g = 0; g < 3; g++) begin
      int nk = 4 + 2 * g;
      int lst = 4 * (nk + 7) - 1;
      m_done[g] = 0;
      if (m_run[g] == 0) begin
        if (start) begin m_run[g] = 1; m_i[g] = nk; end
      end else begin
        if (start) m_err[g] = 1;
        if (abort) m_run[g] = 0;
        else if (ready) begin
          if (m_i[g] == lst) begin m_run[g] = 0; m_done[g] = 1; end
          else m_i[g]++;
        end
      end
    end
  endtask

  // Called at a falling edge: check, then advance one clock.
  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_until_idx0(input int target);
    int n = 0;
    while (!(m_run[0] != 0 && m_i[0] == target) && n < 200) begin cycle(); n++; end
    if (n >= 200) chk("timeout_idx", 32'(n), 32'(0));
  endtask

  task automatic drain();
    int n = 0;
    ready = 1'b1;
    while ((m_run[0] | m_run[1] | m_run[2]) != 0 && n < 400) begin cycle(); n++; end
    if (n >= 400) chk("timeout_drain", 32'(n), 32'(0));
    cycle();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_outputs();               // reset values
    rst = 1'b0;

    // Full schedules with ready high, plus earliest restart on NK=4
    ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    begin
      int n = 0;
      while (m_done[0] == 0 && n < 100) begin cycle(); n++; end
      if (n >= 100) chk("timeout_done", 32'(n), 32'(0));
    end
    start = 1'b1; cycle(); start = 1'b0;
    drain();

    // Backpressure at idx 8 for three cycles
    start = 1'b1; cycle(); start = 1'b0;
    run_until_idx0(8);
    ready = 1'b0;
    repeat (3) cycle();
    ready = 1'b1;
    repeat (3) cycle();
    drain();

    // Start while busy at idx 10, abort at idx 20, fresh restart
    start = 1'b1; cycle(); start = 1'b0;
    run_until_idx0(10);
    start = 1'b1; cycle(); start = 1'b0;
    run_until_idx0(20);
    abort = 1'b1; cycle(); abort = 1'b0;
    cycle();
    abort = 1'b1; cycle(); abort = 1'b0;   // abort in idle: no effect
    start = 1'b1; abort = 1'b1; cycle(); start = 1'b0; abort = 1'b0;
    repeat (6) cycle();
    drain();

    // Asynchronous reset mid-cycle at idx 30
    start = 1'b1; cycle(); start = 1'b0;
    run_until_idx0(30);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (6) cycle();
    drain();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 59) == 0);
      ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    start = 1'b0; abort = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
